// File: rtl/cpu_pkg.sv
// Shared CPU types: opcodes, instruction word, sequencer states.
// Used by the instruction sequencer, its FIFO and its handshake interface.
package cpu_pkg;

    localparam int DATA_W = 8;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_NOP   = 6'h00;
    localparam opcode_t OP_LOADA = 6'h01;
    localparam opcode_t OP_LOADB = 6'h02;
    localparam opcode_t OP_ADD   = 6'h03;
    localparam opcode_t OP_SUB   = 6'h04;
    localparam opcode_t OP_AND   = 6'h05;
    localparam opcode_t OP_OR    = 6'h06;
    localparam opcode_t OP_XOR   = 6'h07;

    typedef struct packed {
        opcode_t             op;
        logic [DATA_W-1:0]   imm;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        HALTED
    } seq_state_e;

    function automatic logic is_known(opcode_t op);
        return (op >= OP_LOADA) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Valid/ready handshake carrying {opcode, imm} words into the sequencer.
// master drives words in; slave (the sequencer) returns ready.
interface instr_sequencer_if;
    import cpu_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    opcode_t             instr_opcode;
    logic [DATA_W-1:0]   instr_imm;

    modport master (
        output instr_valid, instr_opcode, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/seq_fifo.sv
// Synchronous FIFO with occupancy count; clear empties it in one cycle.
// Pointers wrap modulo DEPTH (power of two); cnt tells full from empty.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rdata   = mem[rptr];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Issue controller: FIFO -> DECODE -> EXEC, with HALT/resume and flush.
// Define SEQ_PERF_CNT_EN to add retired_cnt / nop_cnt counters.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int      FIFO_DEPTH  = 4,
    parameter opcode_t HALT_OPCODE = 6'h3F
) (
    input  logic                          clk,
    input  logic                          rst_n,
    instr_sequencer_if.slave              bus,
    input  logic                          flush,
    input  logic                          resume,
    output opcode_t                       opcode,
    output logic [DATA_W-1:0]             imm,
    output logic                          exec_en,
    output logic                          busy,
    output logic                          halted,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                   retired_cnt,
    output logic [31:0]                   nop_cnt
`endif
);

    seq_state_e state;
    seq_state_e state_nx;
    instr_t     issue;
    instr_t     head;
    instr_t     wr_word;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    assign bus.instr_ready = ~full & ~flush;
    assign push    = bus.instr_valid & bus.instr_ready;
    assign pop     = (state == IDLE) & ~empty & ~flush;
    assign wr_word = '{op: bus.instr_opcode, imm: bus.instr_imm};
    assign busy    = ~empty | (state != IDLE);

    seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(instr_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_word),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            issue <= '0;
        end else begin
            state <= state_nx;
            if (flush)    issue <= '0;
            else if (pop) issue <= head;
        end
    end

    always_comb begin
        state_nx = state;
        opcode   = OP_NOP;
        imm      = '0;
        exec_en  = 1'b0;
        halted   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) state_nx = DECODE;
            end
            DECODE: begin
                opcode   = issue.op;
                imm      = issue.imm;
                state_nx = (issue.op == HALT_OPCODE) ? HALTED : EXEC;
            end
            EXEC: begin
                opcode   = issue.op;
                imm      = issue.imm;
                exec_en  = ~flush;
                state_nx = IDLE;
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) state_nx = IDLE;
            end
        endcase
        // flush wins over every other transition, including resume
        if (flush) state_nx = IDLE;
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            nop_cnt     <= '0;
        end else if (exec_en) begin
            if (retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
            if (!is_known(issue.op) && nop_cnt != '1)
                nop_cnt <= nop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table plus corner sequences.
// Writes are checked against a queue of expected {opcode, imm} words.
module tb_instr_sequencer;
    import cpu_pkg::*;

    localparam opcode_t HALT = 6'h3F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic resume = 1'b0;
    opcode_t opcode;
    logic [DATA_W-1:0] imm;
    logic exec_en, busy, halted;
    logic [2:0] fifo_level;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, nop_cnt;
`endif

    int total = 0;
    int bad = 0;
    instr_t sb[$];

    instr_sequencer_if bus();

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .resume     (resume),
        .opcode     (opcode),
        .imm        (imm),
        .exec_en    (exec_en),
        .busy       (busy),
        .halted     (halted),
        .fifo_level (fifo_level)
`ifdef SEQ_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .nop_cnt    (nop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Drive one word; returns 1ns after the edge that accepted it.
    task automatic push(opcode_t op, logic [7:0] im);
        logic acc;
        acc = 1'b0;
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = op;
        bus.instr_imm    = im;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.instr_ready;
            tick();
        end
        bus.instr_valid = 1'b0;
        if (acc) begin
            if (op != HALT) sb.push_back('{op: op, imm: im});
        end else begin
            total++;
            bad++;
            $display("FAIL push_timeout: got no ready want ready op %0h", op);
        end
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 40; i++) begin
            tick();
            samp();
            if (halted) break;
        end
        chk("halted_reached", {31'b0, halted}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            tick();
            samp();
            if (!busy && sb.size() == 0) break;
        end
        chk("drain_busy", {31'b0, busy}, 32'd0);
        chk("drain_sb_left", sb.size(), 32'd0);
    endtask

    // Every write strobe must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && exec_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL exec_unexpected: got op %0h want no write", opcode);
            end else begin
                instr_t e;
                e = sb.pop_front();
                chk("exec_op", {26'b0, opcode}, {26'b0, e.op});
                chk("exec_imm", {24'b0, imm}, {24'b0, e.imm});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        opcode_t    op;
        logic [7:0] im;
        logic       is_halt;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{OP_ADD,   8'h00, 1'b0};
        vt[1] = '{OP_LOADA, 8'h5A, 1'b0};
        vt[2] = '{OP_LOADB, 8'hA5, 1'b0};
        vt[3] = '{OP_SUB,   8'h3C, 1'b0};
        vt[4] = '{OP_XOR,   8'hFF, 1'b0};
        vt[5] = '{6'h09,    8'h11, 1'b0};
        vt[6] = '{HALT,     8'h00, 1'b1};

        bus.instr_valid  = 1'b0;
        bus.instr_opcode = '0;
        bus.instr_imm    = '0;

        #12;
        chk("rst_opcode", {26'b0, opcode}, 32'd0);
        chk("rst_exec", {31'b0, exec_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_level", {29'b0, fifo_level}, 32'd0);
        tick();
        rst_n = 1'b1;
        samp();
        chk("rst_ready", {31'b0, bus.instr_ready}, 32'd1);

        // single-instruction latency per table row
        foreach (vt[k]) begin
            tick();
            push(vt[k].op, vt[k].im);
            tick();
            samp();
            chk("dec_op", {26'b0, opcode}, {26'b0, vt[k].op});
            chk("dec_exec", {31'b0, exec_en}, 32'd0);
            tick();
            samp();
            if (vt[k].is_halt) begin
                chk("halt_flag", {31'b0, halted}, 32'd1);
                chk("halt_op", {26'b0, opcode}, 32'd0);
                chk("halt_exec", {31'b0, exec_en}, 32'd0);
                tick();
                resume = 1'b1;
                tick();
                resume = 1'b0;
                samp();
                chk("resume_halted", {31'b0, halted}, 32'd0);
            end else begin
                chk("ex_exec", {31'b0, exec_en}, 32'd1);
                tick();
                samp();
                chk("post_op", {26'b0, opcode}, 32'd0);
                chk("post_busy", {31'b0, busy}, 32'd0);
            end
        end

        // fill to full while halted, then check ready reopens after a pop
        tick();
        push(HALT, 8'h00);
        push(OP_LOADA, 8'h01);
        push(OP_LOADB, 8'h02);
        push(OP_ADD, 8'h03);
        push(OP_SUB, 8'h04);
        samp();
        chk("full_ready", {31'b0, bus.instr_ready}, 32'd0);
        chk("full_level", {29'b0, fifo_level}, 32'd4);
        tick();
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = OP_AND;
        bus.instr_imm    = 8'h05;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        samp();
        chk("full_after_resume", {31'b0, bus.instr_ready}, 32'd0);
        tick();
        samp();
        chk("pop_level", {29'b0, fifo_level}, 32'd3);
        chk("pop_ready", {31'b0, bus.instr_ready}, 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        sb.push_back('{op: OP_AND, imm: 8'h05});
        samp();
        chk("fifth_level", {29'b0, fifo_level}, 32'd4);
        drain();

        // HALT between two loads keeps the second buffered
        tick();
        push(OP_LOADA, 8'h5A);
        push(HALT, 8'h00);
        push(OP_LOADB, 8'hA5);
        wait_halted();
        chk("halt_level", {29'b0, fifo_level}, 32'd1);
        chk("halt_pending", sb.size(), 32'd1);
        tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        drain();

        // flush during DECODE with two entries still buffered
        tick();
        push(HALT, 8'h00);
        wait_halted();
        tick();
        push(OP_SUB, 8'h44);
        push(OP_AND, 8'h55);
        push(OP_OR, 8'h66);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        samp();
        chk("fl_dec_op", {26'b0, opcode}, {26'b0, OP_SUB});
        chk("fl_dec_level", {29'b0, fifo_level}, 32'd2);
        #1;
        flush = 1'b1;
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = OP_XOR;
        bus.instr_imm    = 8'h77;
        #1;
        chk("fl_ready", {31'b0, bus.instr_ready}, 32'd0);
        sb.delete();
        tick();
        flush = 1'b0;
        bus.instr_valid = 1'b0;
        samp();
        chk("fl_level", {29'b0, fifo_level}, 32'd0);
        chk("fl_busy", {31'b0, busy}, 32'd0);
        chk("fl_op", {26'b0, opcode}, 32'd0);
        repeat (4) tick();
        samp();
        chk("fl_quiet", {31'b0, exec_en}, 32'd0);

        // async reset in the middle of EXEC
        tick();
        push(OP_ADD, 8'h12);
        tick();
        tick();
        samp();
        chk("rs_exec_hi", {31'b0, exec_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rs_exec_lo", {31'b0, exec_en}, 32'd0);
        chk("rs_op", {26'b0, opcode}, 32'd0);
        chk("rs_busy", {31'b0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        samp();
        chk("rs_level", {29'b0, fifo_level}, 32'd0);
        chk("rs_ready", {31'b0, bus.instr_ready}, 32'd1);

`ifdef SEQ_PERF_CNT_EN
        chk("pc_rst", retired_cnt, 32'd0);
        tick();
        push(OP_ADD, 8'h01);
        push(6'h09, 8'h02);
        push(OP_XOR, 8'h03);
        drain();
        chk("pc_retired", retired_cnt, 32'd3);
        chk("pc_nop", nop_cnt, 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        samp();
        chk("pc_retired_fl", retired_cnt, 32'd3);
        chk("pc_nop_fl", nop_cnt, 32'd1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
